di_arbiter: RTL and testbench

- Shares the single device-interface register bus (endpoint address, register address, write data, write/read strobes, terminal reset) between two masters.
- Master 0 is the host interface, which has priority. Master 1 is a local on-chip master, such as the power-up register init sequencer or a local controller.
- The block sits between the masters and the terminal decoders, and guarantees that only one master drives the bus at a time.
- Masters switch only at transaction boundaries, with a terminal-reset pulse on every release.

---
 rtl/di_pkg.sv | 16 +
 rtl/di_starve_cnt.sv | 36 +++
 rtl/di_arbiter.sv | 142 ++++++++++++++
 tb/tb_di_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/di_pkg.sv
// Shared definitions for the device-interface arbiter.
//   - di_state_e : arbiter FSM state encoding
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
package di_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    SWITCH = 2'd3
  } di_state_e;

endpackage

// File: rtl/di_starve_cnt.sv
// Saturating wait counter for the local master.
// Ports:
//   if_clock, resetb : clock, async active-low reset
//   en               : count this cycle (saturates at LIMIT)
//   clr              : clear to zero (wins over en)
//   at_limit         : counter equals LIMIT
module di_starve_cnt
  import di_pkg::*;
#(
  parameter int LIMIT = 64,
  parameter int CNT_W = 7
) (
  input  logic if_clock,
  input  logic resetb,
  input  logic en,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIMIT_C);

endmodule

// File: rtl/di_arbiter.sv
// Two-master arbiter for the device-interface register bus.
// Master 0 (host) has priority; master 1 (local) wins after waiting
// STARVE_LIMIT cycles. Ownership changes only when the owner drops its
// req, and every release goes through a one-cycle SWITCH state that
// pulses di_reset and forces the strobes low.
// Handshake: mX_req is held high for the whole transaction; mX_gnt
// (registered) marks ownership; strobes of a non-owner are ignored;
// mX_rd_ready/mX_wr_ready reach only the current owner.
// Ports:
//   if_clock, resetb            : clock, async active-low reset
//   m0_* / m1_*                 : master request, grant, bus and ready
//   m_rdata                     : read data broadcast to both masters
//   di_*                        : registered bus towards the terminals
//   di_reg_data_out, rd_ready, wr_ready : terminal responses
//   dbg_state                   : current FSM state (debug)
module di_arbiter
  import di_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 64,
  parameter int CNT_W        = 7
) (
  input  logic              if_clock,
  input  logic              resetb,
  input  logic              m0_req,
  output logic              m0_gnt,
  input  logic [ADDR_W-1:0] m0_ep_addr,
  input  logic [ADDR_W-1:0] m0_reg_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_write,
  input  logic              m0_read,
  output logic              m0_rd_ready,
  output logic              m0_wr_ready,
  input  logic              m1_req,
  output logic              m1_gnt,
  input  logic [ADDR_W-1:0] m1_ep_addr,
  input  logic [ADDR_W-1:0] m1_reg_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_write,
  input  logic              m1_read,
  output logic              m1_rd_ready,
  output logic              m1_wr_ready,
  output logic [DATA_W-1:0] m_rdata,
  output logic [ADDR_W-1:0] di_ep_addr,
  output logic [ADDR_W-1:0] di_reg_addr,
  output logic [DATA_W-1:0] di_reg_data_in,
  output logic              di_write,
  output logic              di_read,
  output logic              di_reset,
  input  logic [DATA_W-1:0] di_reg_data_out,
  input  logic              rd_ready,
  input  logic              wr_ready,
  output logic [1:0]        dbg_state
);

  di_state_e state;
  di_state_e next_state;
  logic      starve_hit;
  logic      starve_en;
  logic      starve_clr;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m1_req && starve_hit)  next_state = GRANT1;
        else if (m0_req)           next_state = GRANT0;
        else if (m1_req)           next_state = GRANT1;
      end
      GRANT0:  if (!m0_req) next_state = SWITCH;
      GRANT1:  if (!m1_req) next_state = SWITCH;
      default: next_state = IDLE;
    endcase
  end

  // Master 1 waits whenever it asks but does not own the bus; the count
  // restarts once it gets the bus or gives up asking.
  assign starve_en  = m1_req && (state != GRANT1);
  assign starve_clr = !m1_req || ((next_state == GRANT1) && (state != GRANT1));

  di_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve_cnt (
    .if_clock (if_clock),
    .resetb   (resetb),
    .en       (starve_en),
    .clr      (starve_clr),
    .at_limit (starve_hit)
  );

  // Bus outputs are loaded from the owner while in a GRANT state, so a
  // strobe presented on the owner's last cycle is still issued once.
  // The SWITCH cycle then clears the strobes before anyone else owns.
  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      state          <= IDLE;
      m0_gnt         <= 1'b0;
      m1_gnt         <= 1'b0;
      di_ep_addr     <= '0;
      di_reg_addr    <= '0;
      di_reg_data_in <= '0;
      di_write       <= 1'b0;
      di_read        <= 1'b0;
      di_reset       <= 1'b0;
    end else begin
      state    <= next_state;
      m0_gnt   <= (state == GRANT0) && m0_req;
      m1_gnt   <= (state == GRANT1) && m1_req;
      di_reset <= (next_state == SWITCH);
      case (state)
        GRANT0: begin
          di_ep_addr     <= m0_ep_addr;
          di_reg_addr    <= m0_reg_addr;
          di_reg_data_in <= m0_wdata;
          di_write       <= m0_write;
          di_read        <= m0_read;
        end
        GRANT1: begin
          di_ep_addr     <= m1_ep_addr;
          di_reg_addr    <= m1_reg_addr;
          di_reg_data_in <= m1_wdata;
          di_write       <= m1_write;
          di_read        <= m1_read;
        end
        default: begin
          di_write <= 1'b0;
          di_read  <= 1'b0;
        end
      endcase
    end
  end

  assign m0_rd_ready = (state == GRANT0) && rd_ready;
  assign m0_wr_ready = (state == GRANT0) && wr_ready;
  assign m1_rd_ready = (state == GRANT1) && rd_ready;
  assign m1_wr_ready = (state == GRANT1) && wr_ready;
  assign m_rdata     = di_reg_data_out;
  assign dbg_state   = state;

endmodule

// File: tb/tb_di_arbiter.sv
module tb_di_arbiter;
  import di_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SW = 2 * AW + DW + 2;

  logic          if_clock;
  logic          resetb;
  logic          m0_req, m0_gnt, m0_write, m0_read, m0_rd_ready, m0_wr_ready;
  logic [AW-1:0] m0_ep_addr, m0_reg_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_gnt, m1_write, m1_read, m1_rd_ready, m1_wr_ready;
  logic [AW-1:0] m1_ep_addr, m1_reg_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] di_ep_addr, di_reg_addr;
  logic [DW-1:0] di_reg_data_in, di_reg_data_out;
  logic          di_write, di_read, di_reset, rd_ready, wr_ready;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q[$];

  di_arbiter dut (
    .if_clock(if_clock), .resetb(resetb),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_ep_addr(m0_ep_addr),
    .m0_reg_addr(m0_reg_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
    .m0_read(m0_read), .m0_rd_ready(m0_rd_ready), .m0_wr_ready(m0_wr_ready),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_ep_addr(m1_ep_addr),
    .m1_reg_addr(m1_reg_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
    .m1_read(m1_read), .m1_rd_ready(m1_rd_ready), .m1_wr_ready(m1_wr_ready),
    .m_rdata(m_rdata), .di_ep_addr(di_ep_addr), .di_reg_addr(di_reg_addr),
    .di_reg_data_in(di_reg_data_in), .di_write(di_write), .di_read(di_read),
    .di_reset(di_reset), .di_reg_data_out(di_reg_data_out),
    .rd_ready(rd_ready), .wr_ready(wr_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  initial if_clock = 1'b0;
  always #5 if_clock = ~if_clock;

  // driver tasks
  task automatic clear_inputs;
    m0_req = 0; m0_write = 0; m0_read = 0;
    m0_ep_addr = '0; m0_reg_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_read = 0;
    m1_ep_addr = '0; m1_reg_addr = '0; m1_wdata = '0;
    rd_ready = 0; wr_ready = 0; di_reg_data_out = '0;
  endtask

  // Advance one cycle and score any strobe the bus issues.
  task automatic tick;
    logic [SW-1:0] obs;
    logic [SW-1:0] exp;
    @(posedge if_clock);
    #1;
    if (di_write === 1'b1 || di_read === 1'b1) begin
      obs = {di_ep_addr, di_reg_addr, di_reg_data_in, di_write, di_read};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_strobe: got %h, required no strobe", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          errors++;
          $display("FAIL bus_strobe: got %h, required %h", obs, exp);
        end
      end
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    resetb = 0;
    #2;
    checks++;
    if ({m0_gnt, m1_gnt, di_write, di_read, di_reset} !== 5'b0 ||
        di_ep_addr !== '0 || di_reg_data_in !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b w=%b r=%b rst=%b st=%0d, required all 0",
               m0_gnt, m1_gnt, di_write, di_read, di_reset, dbg_state);
    end
    @(negedge if_clock);
    @(negedge if_clock);
    resetb = 1;
    tick();
    checks++;
    if (dbg_state !== 2'd0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: st=%0d gnt=%b%b, required 0 00", dbg_state, m0_gnt, m1_gnt);
    end
  endtask

  task automatic test_m1_alone;
    m1_req = 1;
    tick();
    checks++;
    if (m1_gnt !== 1'b0) begin
      errors++; $display("FAIL m1_gnt_cycle1: got %b, required 0", m1_gnt);
    end
    tick();
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
      errors++; $display("FAIL m1_gnt_cycle2: got m1=%b m0=%b, required 1 0", m1_gnt, m0_gnt);
    end
    rd_ready = 1;
    #1;
    checks++;
    if (m1_rd_ready !== 1'b1 || m0_rd_ready !== 1'b0) begin
      errors++; $display("FAIL m1_rd_route: got m1=%b m0=%b, required 1 0", m1_rd_ready, m0_rd_ready);
    end
    rd_ready = 0;
    m1_ep_addr = 16'h0003; m1_reg_addr = 16'h0010; m1_wdata = 16'hBEEF; m1_write = 1;
    exp_q.push_back({16'h0003, 16'h0010, 16'hBEEF, 1'b1, 1'b0});
    tick();
    checks++;
    if (di_write !== 1'b1) begin
      errors++; $display("FAIL m1_write: got %b, required 1", di_write);
    end
    m1_write = 0;
    tick();
    m1_req = 0;
    tick();
    checks++;
    if (di_reset !== 1'b1 || dbg_state !== 2'd3) begin
      errors++; $display("FAIL m1_release: rst=%b st=%0d, required 1 3", di_reset, dbg_state);
    end
    tick();
    checks++;
    if (di_reset !== 1'b0 || dbg_state !== 2'd0 || m1_gnt !== 1'b0) begin
      errors++; $display("FAIL m1_after_switch: rst=%b st=%0d gnt=%b, required 0 0 0",
                         di_reset, dbg_state, m1_gnt);
    end
  endtask

  // Both request together; host wins, holds 100 cycles, then the
  // saturated wait counter hands the bus to master 1.
  task automatic test_priority_starvation;
    int bad;
    m0_req = 1; m1_req = 1;
    tick(); tick();
    rd_ready = 1;
    #1;
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || m1_rd_ready !== 1'b0 || m0_rd_ready !== 1'b1) begin
      errors++; $display("FAIL simultaneous: gnt=%b%b rdy=%b%b, required 10 10",
                         m0_gnt, m1_gnt, m0_rd_ready, m1_rd_ready);
    end
    rd_ready = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL no_preempt: %0d bad cycles, required 0", bad);
    end
    m0_req = 0;
    tick();
    checks++;
    if (di_reset !== 1'b1 || m0_gnt !== 1'b0) begin
      errors++; $display("FAIL m0_release: rst=%b gnt=%b, required 1 0", di_reset, m0_gnt);
    end
    m0_req = 1;
    tick(); tick(); tick();
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || dbg_state !== 2'd2) begin
      errors++; $display("FAIL starve_win: gnt=%b%b st=%0d, required 01 2", m0_gnt, m1_gnt, dbg_state);
    end
    m0_req = 0; m1_req = 0;
    settle(3);
  endtask

  task automatic test_drop_with_read;
    m0_req = 1;
    tick(); tick();
    m0_ep_addr = 16'h0007; m0_reg_addr = 16'h0042; m0_wdata = 16'h5A5A;
    m0_read = 1; m0_req = 0;
    exp_q.push_back({16'h0007, 16'h0042, 16'h5A5A, 1'b0, 1'b1});
    tick();
    checks++;
    if (di_read !== 1'b1 || di_reset !== 1'b1) begin
      errors++; $display("FAIL drop_read_pulse: rd=%b rst=%b, required 1 1", di_read, di_reset);
    end
    m1_req = 1;
    tick();
    checks++;
    if (di_read !== 1'b0) begin
      errors++; $display("FAIL drop_read_switch: got %b, required 0", di_read);
    end
    tick(); tick();
    checks++;
    if (di_read !== 1'b0 || m1_gnt !== 1'b1) begin
      errors++; $display("FAIL drop_read_leak: rd=%b gnt1=%b, required 0 1", di_read, m1_gnt);
    end
    m0_read = 0; m1_req = 0;
    settle(3);
  endtask

  task automatic test_reset_mid;
    m0_req = 1;
    tick(); tick();
    m0_write = 1; m0_ep_addr = 16'h0001; m0_reg_addr = 16'h0002; m0_wdata = 16'hCAFE;
    exp_q.push_back({16'h0001, 16'h0002, 16'hCAFE, 1'b1, 1'b0});
    tick();
    #2;
    resetb = 0;
    #1;
    checks++;
    if (di_write !== 1'b0 || m0_gnt !== 1'b0 || di_reset !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL async_reset: w=%b gnt=%b rst=%b st=%0d, required 0 0 0 0",
                         di_write, m0_gnt, di_reset, dbg_state);
    end
    clear_inputs();
    @(negedge if_clock);
    resetb = 1;
    tick();
    checks++;
    if (dbg_state !== 2'd0 || di_reset !== 1'b0) begin
      errors++; $display("FAIL reset_release: st=%0d rst=%b, required 0 0", dbg_state, di_reset);
    end
  endtask

  task automatic test_non_owner;
    int bad;
    m0_req = 1;
    tick(); tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      m0_write    = 1'($urandom_range(0, 1));
      m0_wdata    = 16'($urandom_range(0, 16'hFFFF));
      m0_ep_addr  = 16'($urandom_range(0, 16'hFFFF));
      m0_reg_addr = 16'($urandom_range(0, 16'hFFFF));
      m1_write    = ~m1_write;
      m1_read     = 1'b1;
      m1_wdata    = 16'h1234;
      if (m0_write) exp_q.push_back({m0_ep_addr, m0_reg_addr, m0_wdata, 1'b1, 1'b0});
      tick();
      if (di_reg_data_in !== m0_wdata || di_write !== m0_write || di_read !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL non_owner_ignored: %0d bad cycles, required 0", bad);
    end
    clear_inputs();
    settle(3);
  endtask

  initial begin
    test_reset();
    test_m1_alone();
    test_priority_starvation();
    test_drop_with_read();
    test_reset_mid();
    test_non_owner();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
